// File: rtl/ex_result_stage.sv
// rtl/ex_result_stage.sv - two-entry skid buffer carrying ALU results and resolved branch outcomes (optional BRANCH_STATS_EN adds o_taken_count)
module ex_result_stage #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  i_rst,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [DATA_WIDTH-1:0] i_alu_result,
  input  logic [3:0]            i_flags,
  input  logic                  i_branch,
  input  logic [2:0]            i_funct3,
  input  logic [ADDR_WIDTH-1:0] i_rd_addr,
  input  logic                  i_reg_write,
  input  logic                  i_flush,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [DATA_WIDTH-1:0] o_result,
  output logic [ADDR_WIDTH-1:0] o_rd_addr,
  output logic                  o_reg_write,
  output logic                  o_branch_taken
`ifdef BRANCH_STATS_EN
  ,
  output logic [31:0]           o_taken_count
`endif
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } state_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] result;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic                  reg_write;
    logic                  taken;
  } entry_t;

  state_t state;
  entry_t head;      // output slot, drives the payload ports
  entry_t tail;      // skid slot, filled only when the head is stalled
  entry_t in_entry;

  logic accept;
  logic take;
  logic cond;

  // flag fields as packed by the ALU: {overflow, zero, negative, carry}
  logic flag_v, flag_z, flag_n, flag_c;
  assign flag_v = i_flags[3];
  assign flag_z = i_flags[2];
  assign flag_n = i_flags[1];
  assign flag_c = i_flags[0];

  assign accept = i_valid & o_ready;
  assign take   = o_valid & i_ready;

  // Resolve the branch condition from the SUB flags; carry is the unsigned borrow
  always_comb begin
    cond = 1'b0;
    case (i_funct3)
      3'b000:  cond = flag_z;
      3'b001:  cond = ~flag_z;
      3'b100:  cond = flag_n ^ flag_v;
      3'b101:  cond = ~(flag_n ^ flag_v);
      3'b110:  cond = flag_c;
      3'b111:  cond = ~flag_c;
      default: cond = 1'b0;
    endcase
  end

  // Build the entry to store: branches never write the register file
  always_comb begin
    in_entry           = '0;
    in_entry.result    = i_alu_result;
    in_entry.rd_addr   = i_rd_addr;
    in_entry.reg_write = i_reg_write & ~i_branch;
    in_entry.taken     = i_branch & cond;
  end

  // Skid-buffer state machine; o_ready is registered from the next state
  always_ff @(posedge clk) begin
    if (i_rst) begin
      state   <= S_EMPTY;
      o_valid <= 1'b0;
      o_ready <= 1'b1;
      head    <= '0;
      tail    <= '0;
    end else if (i_flush) begin
      state   <= S_EMPTY;
      o_valid <= 1'b0;
      o_ready <= 1'b1;
      head    <= '0;
      tail    <= '0;
    end else begin
      case (state)
        S_EMPTY: begin
          if (accept) begin
            head    <= in_entry;
            o_valid <= 1'b1;
            state   <= S_ONE;
          end
        end
        S_ONE: begin
          if (accept && !take) begin
            tail    <= in_entry;
            o_ready <= 1'b0;
            state   <= S_TWO;
          end else if (accept && take) begin
            head    <= in_entry;
          end else if (take) begin
            head    <= '0;
            o_valid <= 1'b0;
            state   <= S_EMPTY;
          end
        end
        S_TWO: begin
          if (take) begin
            head    <= tail;
            tail    <= '0;
            o_ready <= 1'b1;
            state   <= S_ONE;
          end
        end
        default: begin
          state   <= S_EMPTY;
          o_valid <= 1'b0;
          o_ready <= 1'b1;
          head    <= '0;
          tail    <= '0;
        end
      endcase
    end
  end

  assign o_result       = head.result;
  assign o_rd_addr      = head.rd_addr;
  assign o_reg_write    = head.reg_write;
  assign o_branch_taken = head.taken;

`ifdef BRANCH_STATS_EN
  logic [31:0] taken_count;

  // Count taken branches leaving the stage; a flush does not clear the total
  always_ff @(posedge clk) begin
    if (i_rst) begin
      taken_count <= '0;
    end else if (take && o_branch_taken) begin
      taken_count <= taken_count + 32'd1;
    end
  end

  assign o_taken_count = taken_count;
`endif

endmodule

// File: tb/tb_ex_result_stage.sv
// tb/tb_ex_result_stage.sv - scoreboard bench for ex_result_stage
module tb_ex_result_stage;

  logic        clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_valid = 1'b0;
  logic        o_ready;
  logic [31:0] i_alu_result = '0;
  logic [3:0]  i_flags = '0;
  logic        i_branch = 1'b0;
  logic [2:0]  i_funct3 = '0;
  logic [4:0]  i_rd_addr = '0;
  logic        i_reg_write = 1'b0;
  logic        i_flush = 1'b0;
  logic        o_valid;
  logic        i_ready = 1'b0;
  logic [31:0] o_result;
  logic [4:0]  o_rd_addr;
  logic        o_reg_write;
  logic        o_branch_taken;
`ifdef BRANCH_STATS_EN
  logic [31:0] o_taken_count;
`endif

  ex_result_stage #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
    .clk            (clk),
    .i_rst          (i_rst),
    .i_valid        (i_valid),
    .o_ready        (o_ready),
    .i_alu_result   (i_alu_result),
    .i_flags        (i_flags),
    .i_branch       (i_branch),
    .i_funct3       (i_funct3),
    .i_rd_addr      (i_rd_addr),
    .i_reg_write    (i_reg_write),
    .i_flush        (i_flush),
    .o_valid        (o_valid),
    .i_ready        (i_ready),
    .o_result       (o_result),
    .o_rd_addr      (o_rd_addr),
    .o_reg_write    (o_reg_write),
    .o_branch_taken (o_branch_taken)
`ifdef BRANCH_STATS_EN
    ,
    .o_taken_count  (o_taken_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] result;
    logic [4:0]  rd;
    logic        rw;
    logic        tk;
  } exp_t;

  exp_t        q[$];
  int          total = 0;
  int          bad = 0;
  string       phase = "reset";
  logic        last_acc = 1'b0;
  logic [31:0] cnt = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s/%s: observed=%0h expected=%0h", phase, tag, obs, exp);
    end
  endtask

  // Branch truth table over flags {overflow, zero, negative, carry}
  function automatic logic model_taken(input logic br, input logic [2:0] f3, input logic [3:0] fl);
    logic v, z, n, c;
    v = fl[3]; z = fl[2]; n = fl[1]; c = fl[0];
    if (!br) return 1'b0;
    case (f3)
      3'b000:  return z;
      3'b001:  return !z;
      3'b100:  return n != v;
      3'b101:  return n == v;
      3'b110:  return c;
      3'b111:  return !c;
      default: return 1'b0;
    endcase
  endfunction

  task automatic drive(input logic v, input logic [31:0] res, input logic [4:0] rd, input logic rw,
                       input logic br, input logic [2:0] f3, input logic [3:0] fl);
    i_valid = v; i_alu_result = res; i_rd_addr = rd; i_reg_write = rw;
    i_branch = br; i_funct3 = f3; i_flags = fl;
  endtask

  // Check outputs against the model, then advance one clock and update the model
  task automatic tick();
    logic acc, take;
    exp_t e;
    chk("o_valid", 32'(o_valid), 32'(q.size() > 0));
    chk("o_ready", 32'(o_ready), 32'(q.size() < 2));
    if (q.size() > 0) begin
      chk("o_result", o_result, q[0].result);
      chk("o_rd_addr", 32'(o_rd_addr), 32'(q[0].rd));
      chk("o_reg_write", 32'(o_reg_write), 32'(q[0].rw));
      chk("o_branch_taken", 32'(o_branch_taken), 32'(q[0].tk));
    end else begin
      chk("o_result_idle", o_result, 32'h0);
      chk("o_rd_addr_idle", 32'(o_rd_addr), 32'h0);
      chk("o_reg_write_idle", 32'(o_reg_write), 32'h0);
      chk("o_branch_taken_idle", 32'(o_branch_taken), 32'h0);
    end
`ifdef BRANCH_STATS_EN
    chk("o_taken_count", o_taken_count, cnt);
`endif
    acc = i_valid && (q.size() < 2) && !i_rst;
    take = (q.size() > 0) && i_ready && !i_rst;
    e.result = i_alu_result;
    e.rd = i_rd_addr;
    e.rw = i_reg_write && !i_branch;
    e.tk = model_taken(i_branch, i_funct3, i_flags);
    @(posedge clk);
    #1;
    if (i_rst) begin
      q.delete();
      cnt = '0;
      last_acc = 1'b0;
    end else begin
      if (take) begin
        if (q[0].tk) cnt = cnt + 32'd1;
        void'(q.pop_front());
      end
      if (i_flush) q.delete();
      else if (acc) q.push_back(e);
      last_acc = acc && !i_flush;
    end
  endtask

  task automatic send_wait();
    for (int k = 0; k < 10; k++) begin
      tick();
      if (last_acc) break;
    end
    chk("accept_in_time", 32'(last_acc), 32'h1);
  endtask

  initial begin
    i_rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    i_rst = 1'b0;

    phase = "reset_state";
    tick();

    phase = "single";
    i_ready = 1'b1;
    drive(1'b1, 32'h0000_1234, 5'd5, 1'b1, 1'b0, 3'b000, 4'h0);
    tick();
    drive(1'b0, '0, '0, 1'b0, 1'b0, 3'b000, 4'h0);
    tick();
    tick();

    phase = "backpressure";
    i_ready = 1'b0;
    drive(1'b1, 32'hAAAA_0001, 5'd1, 1'b1, 1'b0, 3'b000, 4'h0);
    tick();
    drive(1'b1, 32'hBBBB_0002, 5'd2, 1'b1, 1'b0, 3'b000, 4'h0);
    tick();
    drive(1'b1, 32'hCCCC_0003, 5'd3, 1'b0, 1'b0, 3'b000, 4'h0);
    tick();
    tick();
    i_ready = 1'b1;
    send_wait();
    drive(1'b0, '0, '0, 1'b0, 1'b0, 3'b000, 4'h0);
    repeat (3) tick();

    phase = "branches";
    i_ready = 1'b1;
    drive(1'b1, 32'h0, 5'd7, 1'b1, 1'b1, 3'b000, 4'b0100); tick();
    drive(1'b1, 32'h0, 5'd8, 1'b1, 1'b1, 3'b001, 4'b0100); tick();
    drive(1'b1, 32'h0, 5'd9, 1'b1, 1'b1, 3'b100, 4'b0010); tick();
    drive(1'b1, 32'h0, 5'd10, 1'b1, 1'b1, 3'b111, 4'b0001); tick();
    drive(1'b1, 32'h5, 5'd11, 1'b1, 1'b1, 3'b101, 4'b1010); tick();
    drive(1'b1, 32'h6, 5'd12, 1'b1, 1'b1, 3'b110, 4'b0001); tick();
    drive(1'b1, 32'h7, 5'd13, 1'b1, 1'b1, 3'b010, 4'b1111); tick();
    drive(1'b1, 32'h8, 5'd14, 1'b1, 1'b0, 3'b000, 4'b0100); tick();
    drive(1'b0, '0, '0, 1'b0, 1'b0, 3'b000, 4'h0);
    repeat (2) tick();

    phase = "flush_two";
    i_ready = 1'b0;
    drive(1'b1, 32'h1111_0001, 5'd1, 1'b1, 1'b0, 3'b000, 4'h0); tick();
    drive(1'b1, 32'h1111_0002, 5'd2, 1'b1, 1'b0, 3'b000, 4'h0); tick();
    drive(1'b1, 32'h1111_0003, 5'd3, 1'b1, 1'b0, 3'b000, 4'h0);
    i_flush = 1'b1;
    tick();
    i_flush = 1'b0;
    drive(1'b0, '0, '0, 1'b0, 1'b0, 3'b000, 4'h0);
    tick();

    phase = "flush_with_output";
    i_ready = 1'b1;
    drive(1'b1, 32'h2222_0001, 5'd4, 1'b1, 1'b1, 3'b000, 4'b0100); tick();
    drive(1'b1, 32'h2222_0002, 5'd5, 1'b1, 1'b0, 3'b000, 4'h0);
    i_flush = 1'b1;
    tick();
    i_flush = 1'b0;
    drive(1'b0, '0, '0, 1'b0, 1'b0, 3'b000, 4'h0);
    tick();

    phase = "reset_mid";
    i_ready = 1'b0;
    drive(1'b1, 32'h3333_0001, 5'd6, 1'b1, 1'b0, 3'b000, 4'h0); tick();
    drive(1'b1, 32'h3333_0002, 5'd7, 1'b1, 1'b0, 3'b000, 4'h0); tick();
    i_rst = 1'b1;
    i_flush = 1'b1;
    i_ready = 1'b1;
    tick();
    i_rst = 1'b0;
    i_flush = 1'b0;
    drive(1'b0, '0, '0, 1'b0, 1'b0, 3'b000, 4'h0);
    tick();

    phase = "random";
    for (int i = 0; i < 300; i++) begin
      drive(1'(($urandom % 3) != 0), $urandom, 5'($urandom), 1'($urandom), 1'($urandom),
            3'($urandom), 4'($urandom));
      i_ready = 1'(($urandom % 4) != 0);
      i_flush = 1'(($urandom % 29) == 0);
      tick();
    end
    i_flush = 1'b0;
    i_ready = 1'b1;
    drive(1'b0, '0, '0, 1'b0, 1'b0, 3'b000, 4'h0);
    repeat (3) tick();

`ifdef BRANCH_STATS_EN
    phase = "count_wrap";
    force dut.taken_count = 32'hFFFF_FFFF;
    #1;
    release dut.taken_count;
    cnt = 32'hFFFF_FFFF;
    tick();
    drive(1'b1, 32'h0, 5'd1, 1'b0, 1'b1, 3'b000, 4'b0100); tick();
    drive(1'b0, '0, '0, 1'b0, 1'b0, 3'b000, 4'h0);
    tick();
    chk("count_wrapped", o_taken_count, 32'h0);
    tick();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ex_result_stage.md
EX_RESULT_STAGE -- requirements
Module: ex_result_stage

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, width of ALU result and output data.
REQ-002 SHALL have parameter ADDR_WIDTH, default 5, register-file destination address width.
REQ-003 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-004 SHALL have port i_rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port i_valid  input  1  upstream (ALU side) entry valid.
REQ-006 SHALL have port o_ready  output  1  stage can accept an entry this cycle.
REQ-007 SHALL have port i_alu_result  input  DATA_WIDTH  ALU result.
REQ-008 SHALL have port i_flags  input  4  ALU flags packed {overflow, zero, negative, carry}.
REQ-009 SHALL have port i_branch  input  1  entry is a conditional branch compare (ALU performed SUB).
REQ-010 SHALL have port i_funct3  input  3  branch condition code, RV32I encoding.
REQ-011 SHALL have port i_rd_addr  input  ADDR_WIDTH  destination register.
REQ-012 SHALL have port i_reg_write  input  1  entry writes the register file.
REQ-013 SHALL have port i_flush  input  1  discard all held entries.
REQ-014 SHALL have port o_valid  output  1  downstream entry valid.
REQ-015 SHALL have port i_ready  input  1  downstream accepts entry.
REQ-016 SHALL have port o_result, o_rd_addr, o_reg_write  output  DATA_WIDTH / ADDR_WIDTH / 1  registered payload.
REQ-017 SHALL have port o_branch_taken  output  1  held entry is a branch whose condition is true.

Function
REQ-018 SHALL transfer in on i_valid & o_ready and out on o_valid & i_ready; payload SHALL be stable while o_valid & !i_ready.
REQ-019 SHALL be a 2-entry skid buffer, states EMPTY, ONE, TWO; latency input-accept to o_valid = 1 cycle; full throughput of 1 entry/cycle.
REQ-020 EMPTY->ONE on accept; ONE->EMPTY on output-only; ONE->TWO on accept without output; TWO->ONE on output; ONE stays ONE on simultaneous accept and output.
REQ-021 o_ready SHALL be registered, 1 in EMPTY and ONE, 0 in TWO; no combinational path i_ready->o_ready.
REQ-022 Entries SHALL leave in acceptance order; TWO-state second entry moves to output slot on the cycle the first is taken.
REQ-023 o_branch_taken SHALL be computed at accept time and stored with the entry: funct3 000 Z, 001 !Z, 100 N^V, 101 !(N^V), 110 C, 111 !C, 010/011 0.
REQ-024 Carry SHALL be interpreted as unsigned borrow (1 when src1 < src2 unsigned); non-branch entries SHALL store o_branch_taken 0.
REQ-025 For branch entries o_reg_write SHALL be forced to 0 regardless of i_reg_write.
REQ-026 i_flush SHALL move state to EMPTY next cycle, o_valid 0, o_ready 1; flush wins over a simultaneous accept (entry dropped) and over output (handshake on that cycle still counts downstream).
REQ-027 Payload outputs SHALL be don't-care-free: cleared to 0 when the output slot is empty.

Reset
REQ-028 On i_rst high at clk edge: state EMPTY, o_valid 0, o_ready 1, o_result 0, o_rd_addr 0, o_reg_write 0, o_branch_taken 0; reset mid-transfer SHALL drop all entries.
REQ-029 Reset SHALL take priority over i_flush and all handshakes.

Configuration
REQ-030 With macro BRANCH_STATS_EN defined SHALL add output o_taken_count (32 bits), incremented by 1 on each output handshake with o_branch_taken 1, wrapping 0xFFFFFFFF->0, cleared by i_rst only (not by i_flush).
REQ-031 Without BRANCH_STATS_EN the port and counter SHALL not exist; all other behaviour identical.

Verification
REQ-032 Reset then single entry result 0x0000_1234, rd 5, reg_write 1, i_ready 1 -> o_valid 1 next cycle with identical payload, then 0.
REQ-033 i_ready held 0, three back-to-back valids -> first two captured, o_ready 0 after second, third held upstream; release i_ready -> three outputs in order, no loss or duplicate.
REQ-034 Branch entries funct3 000 Z=1, 001 Z=1, 100 N=1 V=0, 111 C=1 -> o_branch_taken 1,0,1,0; o_reg_write 0 for all.
REQ-035 State TWO then i_flush with simultaneous i_valid -> next cycle o_valid 0, o_ready 1, new entry dropped.
REQ-036 BRANCH_STATS_EN: preload-equivalent 2^32-1 taken branches (or force counter to 0xFFFFFFFF), one more taken output -> o_taken_count 0; build without macro compiles with no o_taken_count.
